// File: rtl/teclado_escaneo_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, key codes,
// default timing parameters and small decode helpers.
package teclado_escaneo_pkg;

  typedef enum logic [1:0] {
    ESCANEO     = 2'd0,
    REBOTE_PRES = 2'd1,
    PRESIONADA  = 2'd2,
    REBOTE_LIB  = 2'd3
  } estado_t;

  localparam int SCAN_CICLOS_DEF   = 4;
  localparam int REBOTE_CICLOS_DEF = 8;

  // Non-digit keys share the code space above 9 so one 4-bit value covers every key.
  localparam logic [3:0] TECLA_A   = 4'hA;
  localparam logic [3:0] TECLA_B   = 4'hB;
  localparam logic [3:0] TECLA_C   = 4'hC;
  localparam logic [3:0] TECLA_D   = 4'hD;
  localparam logic [3:0] TECLA_AST = 4'hE;
  localparam logic [3:0] TECLA_NUM = 4'hF;

  function automatic int cnt_ancho(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

  function automatic logic es_onehot(input logic [3:0] v);
    return (v != 4'b0) && ((v & (v - 4'b1)) == 4'b0);
  endfunction

  function automatic logic [1:0] indice(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] decodifica(input logic [3:0] fila, input logic [3:0] col);
    case ({indice(fila), indice(col)})
      4'b00_00: return 4'h1;
      4'b00_01: return 4'h2;
      4'b00_10: return 4'h3;
      4'b00_11: return TECLA_A;
      4'b01_00: return 4'h4;
      4'b01_01: return 4'h5;
      4'b01_10: return 4'h6;
      4'b01_11: return TECLA_B;
      4'b10_00: return 4'h7;
      4'b10_01: return 4'h8;
      4'b10_10: return 4'h9;
      4'b10_11: return TECLA_C;
      4'b11_00: return TECLA_AST;
      4'b11_01: return 4'h0;
      4'b11_10: return TECLA_NUM;
      default:  return TECLA_D;
    endcase
  endfunction

endpackage

// File: rtl/teclado_escaneo_if.sv
// Keypad-side bundle: row sense in, column drive and key events out, plus FSM state.
interface teclado_escaneo_if;
  import teclado_escaneo_pkg::*;

  // No valid/ready: digito_stb, cancelar and aceptar are one-cycle strobes with no
  // back-pressure; digito is qualified by digito_stb and holds between strobes.
  logic [3:0] filas;
  logic [3:0] columnas;
  logic [3:0] digito;
  logic       digito_stb;
  logic       cancelar;
  logic       aceptar;
  estado_t    estado;

  modport master (input filas,
                  output columnas, digito, digito_stb, cancelar, aceptar, estado);
  modport slave  (output filas,
                  input columnas, digito, digito_stb, cancelar, aceptar, estado);
endinterface

// File: rtl/teclado_escaneo_antirrebote_cnt.sv
// Debounce counter with its stability compare; saturates at TERMINAL, cleared by limpiar.
module antirrebote_cnt #(
  parameter int ANCHO    = 4,
  parameter int TERMINAL = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       limpiar,
  input  logic       contar,
  input  logic [3:0] filas_s,
  input  logic [3:0] referencia,
  output logic       estable,
  output logic       fin
);
  localparam logic [ANCHO-1:0] TERM = ANCHO'(TERMINAL);

  logic [ANCHO-1:0] cnt;

  assign estable = (filas_s == referencia);
  assign fin     = (cnt == TERM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (limpiar) begin
      cnt <= '0;
    end else if (contar && estable && !fin) begin
      cnt <= cnt + ANCHO'(1);
    end
  end
endmodule

// File: rtl/teclado_escaneo.sv
// 4x4 keypad scanner: rotates column drive, debounces press and release, and
// emits one registered event per accepted key.
module teclado_escaneo
  import teclado_escaneo_pkg::*;
#(
  parameter int SCAN_CICLOS   = SCAN_CICLOS_DEF,
  parameter int REBOTE_CICLOS = REBOTE_CICLOS_DEF
) (
  input logic               clk,
  input logic               reset,
  teclado_escaneo_if.master bus
);
  localparam int ANCHO = cnt_ancho(SCAN_CICLOS, REBOTE_CICLOS);
  localparam logic [ANCHO-1:0] SCAN_FIN = ANCHO'(SCAN_CICLOS - 1);

  logic [3:0]       filas_m, filas_s;
  estado_t          estado;
  logic [3:0]       columnas, fila_lat, digito, tecla, referencia;
  logic [ANCHO-1:0] scan_cnt;
  logic             digito_stb, cancelar, aceptar;
  logic             limpiar, contar, estable, fin;

  always_ff @(posedge clk) begin
    if (!reset) begin
      filas_m <= 4'b0;
      filas_s <= 4'b0;
    end else begin
      filas_m <= bus.filas;
      filas_s <= filas_m;
    end
  end

  // Press debounce compares against the latched row; every other state watches for all-zero.
  assign referencia = (estado == REBOTE_PRES) ? fila_lat : 4'b0;
  assign limpiar    = (estado == ESCANEO) || (estado == PRESIONADA);
  assign contar     = (estado == REBOTE_PRES) || (estado == REBOTE_LIB);
  assign tecla      = decodifica(fila_lat, columnas);

  antirrebote_cnt #(.ANCHO(ANCHO), .TERMINAL(REBOTE_CICLOS - 1)) u_antirrebote (
    .clk        (clk),
    .reset      (reset),
    .limpiar    (limpiar),
    .contar     (contar),
    .filas_s    (filas_s),
    .referencia (referencia),
    .estable    (estable),
    .fin        (fin)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado     <= ESCANEO;
      columnas   <= 4'b0001;
      scan_cnt   <= '0;
      fila_lat   <= 4'b0;
      digito     <= 4'h0;
      digito_stb <= 1'b0;
      cancelar   <= 1'b0;
      aceptar    <= 1'b0;
    end else begin
      digito_stb <= 1'b0;
      cancelar   <= 1'b0;
      aceptar    <= 1'b0;
      case (estado)
        ESCANEO: begin
          if (es_onehot(filas_s)) begin
            fila_lat <= filas_s;
            estado   <= REBOTE_PRES;
          end else if (scan_cnt == SCAN_FIN) begin
            scan_cnt <= '0;
            columnas <= {columnas[2:0], columnas[3]};
          end else begin
            scan_cnt <= scan_cnt + ANCHO'(1);
          end
        end
        REBOTE_PRES: begin
          if (!estable) begin
            estado   <= ESCANEO;
            scan_cnt <= '0;
            columnas <= {columnas[2:0], columnas[3]};
          end else if (fin) begin
            estado <= PRESIONADA;
            if (tecla <= 4'h9) begin
              digito     <= tecla;
              digito_stb <= 1'b1;
            end else if (tecla == TECLA_AST) begin
              cancelar <= 1'b1;
            end else if (tecla == TECLA_NUM) begin
              aceptar <= 1'b1;
            end
          end
        end
        PRESIONADA: begin
          if (estable) estado <= REBOTE_LIB;
        end
        REBOTE_LIB: begin
          if (!estable) begin
            estado <= PRESIONADA;
          end else if (fin) begin
            estado   <= ESCANEO;
            scan_cnt <= '0;
            columnas <= {columnas[2:0], columnas[3]};
          end
        end
        default: estado <= ESCANEO;
      endcase
    end
  end

  assign bus.columnas   = columnas;
  assign bus.digito     = digito;
  assign bus.digito_stb = digito_stb;
  assign bus.cancelar   = cancelar;
  assign bus.aceptar    = aceptar;
  assign bus.estado     = estado;
endmodule

// File: tb/tb_teclado_escaneo.sv
// Bench for teclado_escaneo: a behavioural keypad drives rows from the column
// drive, and a scoreboard matches every event pulse against queued expectations.
module tb_teclado_escaneo;
  import teclado_escaneo_pkg::*;

  localparam int S = 4;
  localparam int R = 8;

  localparam logic [6:0] EV_5   = {3'b001, 4'h5};
  localparam logic [6:0] EV_8   = {3'b001, 4'h8};
  localparam logic [6:0] EV_9   = {3'b001, 4'h9};
  localparam logic [6:0] EV_0   = {3'b001, 4'h0};
  localparam logic [6:0] EV_AST = {3'b010, 4'h0};
  localparam logic [6:0] EV_NUM = {3'b100, 4'h0};
  localparam logic [6:0] EV_NONE = 7'h0;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  teclado_escaneo_if bus ();

  teclado_escaneo #(.SCAN_CICLOS(S), .REBOTE_CICLOS(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // behavioural keypad: a held key shorts its row to its column
  logic       pressed = 1'b0;
  logic       forzar = 1'b0;
  logic [3:0] key_row = 4'b0;
  logic [3:0] key_col = 4'b0;
  logic [3:0] force_val = 4'b0;
  assign bus.filas = forzar ? force_val :
                     ((pressed && (bus.columnas == key_col)) ? key_row : 4'b0);

  // scoreboard
  logic [6:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_pulsos = 0;
  int         t_pulso = 0;
  logic [6:0] obs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.digito_stb || bus.cancelar || bus.aceptar) begin
      n_pulsos++;
      t_pulso = cyc;
      check_eq("pulse_exclusive", $countones({bus.aceptar, bus.cancelar, bus.digito_stb}), 1);
      obs = {bus.aceptar, bus.cancelar, bus.digito_stb, (bus.digito_stb ? bus.digito : 4'h0)};
      if (exp_q.size() == 0) check_eq("unexpected_pulse", obs, EV_NONE);
      else check_eq("pulse_value", obs, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic wait_col(input logic [3:0] col, input bit igual, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8 * S; i++) begin
      @(negedge clk);
      if ((bus.columnas == col) == igual) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_estado(input estado_t e, input int limite, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limite; i++) begin
      @(negedge clk);
      if (bus.estado == e) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pulsos(input int n, input int limite, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limite; i++) begin
      @(negedge clk);
      if (n_pulsos >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulsar(input string tag, input logic [3:0] row, input logic [3:0] col,
                        input logic [6:0] ev, input int hold);
    bit ok;
    int n0;
    n0 = n_pulsos;
    key_row = row;
    key_col = col;
    wait_col(col, 1'b0, ok);
    if (ev != EV_NONE) exp_q.push_back(ev);
    pressed = 1'b1;
    wait_estado(PRESIONADA, 16 * S + 4 * R, ok);
    check_eq({tag, "_reach_pressed"}, ok, 1);
    repeat (hold) @(negedge clk);
    check_eq({tag, "_pulse_count"}, n_pulsos - n0, (ev != EV_NONE) ? 1 : 0);
    pressed = 1'b0;
    wait_estado(ESCANEO, 8 * R, ok);
    check_eq({tag, "_back_to_scan"}, ok, 1);
    repeat (3) @(negedge clk);
  endtask

  logic [3:0] cur;
  bit         ok;
  bit         frozen;
  int         c0, n0;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_columnas", bus.columnas, 4'b0001);
    check_eq("rst_digito", bus.digito, 4'h0);
    check_eq("rst_pulses", {bus.digito_stb, bus.cancelar, bus.aceptar}, 3'b000);
    check_eq("rst_estado", bus.estado, ESCANEO);
    reset = 1'b1;

    // two rows at once: ignored, scanning keeps its period
    forzar = 1'b1;
    force_val = 4'b0011;
    cur = bus.columnas;
    ok = 1'b0;
    for (int i = 0; i < 2 * S; i++) begin
      @(negedge clk);
      if (bus.columnas != cur) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("multi_row_scan_moves", ok, 1);
    cur = bus.columnas;
    for (int k = 0; k < 6; k++) begin
      repeat (S - 1) @(negedge clk);
      check_eq("multi_row_scan_hold", bus.columnas, cur);
      @(negedge clk);
      cur = {cur[2:0], cur[3]};
      check_eq("multi_row_scan_rot", bus.columnas, cur);
    end
    check_eq("multi_row_estado", bus.estado, ESCANEO);
    forzar = 1'b0;
    repeat (4) @(negedge clk);

    // '5' with latency measured from the first cycle its column is driven
    key_row = 4'b0010;
    key_col = 4'b0010;
    wait_col(4'b0010, 1'b0, ok);
    pressed = 1'b1;
    wait_col(4'b0010, 1'b1, ok);
    check_eq("k5_col_seen", ok, 1);
    c0 = cyc;
    n0 = n_pulsos;
    exp_q.push_back(EV_5);
    wait_pulsos(n0 + 1, 4 * R, ok);
    check_eq("k5_pulse_seen", ok, 1);
    check_eq("k5_latency", t_pulso - c0, R + 3);
    repeat (20 - (R + 3)) @(negedge clk);
    check_eq("k5_held_state", bus.estado, PRESIONADA);
    check_eq("k5_single_pulse", n_pulsos - n0, 1);
    pressed = 1'b0;
    wait_estado(ESCANEO, 8 * R, ok);
    check_eq("k5_release", ok, 1);
    repeat (3) @(negedge clk);

    // letter key: no pulse, but the press is still tracked
    pulsar("kA", 4'b0001, 4'b1000, EV_NONE, 10);

    // bouncing '8' then a clean hold
    key_row = 4'b0100;
    key_col = 4'b0010;
    wait_col(4'b0010, 1'b0, ok);
    wait_col(4'b0010, 1'b1, ok);
    n0 = n_pulsos;
    for (int i = 0; i < 15; i++) begin
      pressed = ((i / 3) % 2) == 0;
      @(negedge clk);
    end
    check_eq("k8_bounce_no_pulse", n_pulsos - n0, 0);
    exp_q.push_back(EV_8);
    pressed = 1'b1;
    wait_pulsos(n0 + 1, 16 * S + 4 * R, ok);
    check_eq("k8_pulse_seen", ok, 1);
    repeat (10) @(negedge clk);
    check_eq("k8_single_pulse", n_pulsos - n0, 1);
    pressed = 1'b0;
    wait_estado(ESCANEO, 8 * R, ok);
    check_eq("k8_release", ok, 1);
    repeat (3) @(negedge clk);

    // '*' then '#'; digito keeps the last digit
    pulsar("kast", 4'b1000, 4'b0001, EV_AST, 10);
    pulsar("knum", 4'b1000, 4'b0100, EV_NUM, 10);
    check_eq("digito_hold", bus.digito, 4'h8);

    // long hold of '0': one pulse, columns frozen until release debounce ends
    key_row = 4'b1000;
    key_col = 4'b0010;
    n0 = n_pulsos;
    wait_col(4'b0010, 1'b0, ok);
    exp_q.push_back(EV_0);
    pressed = 1'b1;
    wait_estado(PRESIONADA, 16 * S + 4 * R, ok);
    check_eq("k0_reach_pressed", ok, 1);
    frozen = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.columnas != 4'b0010) frozen = 1'b0;
    end
    check_eq("k0_hold_frozen", frozen, 1);
    check_eq("k0_single_pulse", n_pulsos - n0, 1);
    pressed = 1'b0;
    frozen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.columnas != 4'b0010) frozen = 1'b0;
    end
    check_eq("k0_release_frozen", frozen, 1);
    wait_estado(ESCANEO, 8 * R, ok);
    check_eq("k0_release", ok, 1);
    repeat (3) @(negedge clk);

    // reset in the middle of debouncing '9'
    key_row = 4'b0100;
    key_col = 4'b0100;
    n0 = n_pulsos;
    wait_col(4'b0100, 1'b0, ok);
    pressed = 1'b1;
    wait_col(4'b0100, 1'b1, ok);
    wait_estado(REBOTE_PRES, 4 * S, ok);
    check_eq("k9_reach_debounce", ok, 1);
    repeat (2) @(negedge clk);
    check_eq("k9_mid_debounce", bus.estado, REBOTE_PRES);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("k9_rst_columnas", bus.columnas, 4'b0001);
    check_eq("k9_rst_estado", bus.estado, ESCANEO);
    check_eq("k9_aborted", n_pulsos - n0, 0);
    reset = 1'b1;
    exp_q.push_back(EV_9);
    wait_col(4'b0100, 1'b1, ok);
    check_eq("k9_col_seen", ok, 1);
    c0 = cyc;
    wait_pulsos(n0 + 1, 4 * R, ok);
    check_eq("k9_pulse_seen", ok, 1);
    check_eq("k9_latency", t_pulso - c0, R + 3);
    repeat (5) @(negedge clk);
    pressed = 1'b0;
    wait_estado(ESCANEO, 8 * R, ok);
    check_eq("k9_release", ok, 1);
    repeat (5) @(negedge clk);
    check_eq("k9_single_pulse", n_pulsos - n0, 1);

    // final report
    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/teclado_escaneo.md
TECLADO_ESCANEO -- requirements
Module: teclado_escaneo

Interface
REQ-001 Parameter SCAN_CICLOS, default 4: clock cycles each column stays driven while scanning.
REQ-002 Parameter REBOTE_CICLOS, default 8: consecutive stable cycles required to accept a press or a release.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 filas  input  4  keypad row sense lines, active-high, asynchronous to clk.
REQ-006 columnas  output  4  one-hot, active-high column drive.
REQ-007 digito  output  4  BCD value of the last accepted digit key.
REQ-008 digito_stb  output  1  one-cycle pulse; digito is valid in the same cycle.
REQ-009 cancelar  output  1  one-cycle pulse when '*' is accepted.
REQ-010 aceptar  output  1  one-cycle pulse when '#' is accepted.

Function
REQ-011 filas pass through a two-flop synchronizer; all logic uses the synchronized value filas_s.
REQ-012 Key map (row,col): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
REQ-013 FSM states: ESCANEO, REBOTE_PRES, PRESIONADA, REBOTE_LIB.
REQ-014 ESCANEO: columnas rotates 0001->0010->0100->1000->0001, each value held SCAN_CICLOS cycles.
REQ-015 ESCANEO: if filas_s is one-hot, latch (row, active column), freeze columnas, load the debounce counter with 0, and go to REBOTE_PRES.
REQ-016 ESCANEO: filas_s with two or more bits set is ignored and scanning continues.
REQ-017 REBOTE_PRES: count up while filas_s equals the latched row; on reaching REBOTE_CICLOS-1, emit the key event and go to PRESIONADA.
REQ-018 REBOTE_PRES: any mismatch returns to ESCANEO, resuming at the next column, with no event.
REQ-019 Key event: digit key -> digito_stb=1 and digito=value; '*' -> cancelar=1; '#' -> aceptar=1; A-D -> no pulse, but the FSM still enters PRESIONADA.
REQ-020 Exactly one event per physical press; holding a key never repeats.
REQ-021 PRESIONADA: columnas stays frozen; when filas_s==0, clear the counter and go to REBOTE_LIB.
REQ-022 REBOTE_LIB: count up while filas_s==0; after REBOTE_CICLOS cycles, go to ESCANEO. Any nonzero filas_s returns to PRESIONADA.
REQ-023 Press latency: the pulse occurs exactly REBOTE_CICLOS+1 cycles after the first cycle filas_s is stable one-hot in ESCANEO.
REQ-024 digito holds its value between strobes; the three pulse outputs are never asserted together.
REQ-025 Counters are sized $clog2(max(SCAN_CICLOS, REBOTE_CICLOS))+1 and never wrap; they saturate at terminal count.

Reset
REQ-026 While reset==0 at a rising edge: state=ESCANEO, columnas=4'b0001, scan counter=0, debounce counter=0, digito=0, digito_stb=0, cancelar=0, aceptar=0, synchronizer flops=0.
REQ-027 Reset asserted mid-debounce or mid-press aborts the press with no pulse; after release of reset, scanning restarts at column 0.

Structure
REQ-028 A shared package holds the FSM state encoding, the key-map constants (codes for '*', '#', A-D), and the default parameter values.
REQ-029 The debounce counter and the stability compare form one sub-module, antirrebote_cnt; the FSM, scan rotation and decode stay in teclado_escaneo.

Verification
REQ-030 Press row1 while column 0010 is driven, stable for 20 cycles, then release -> exactly one digito_stb with digito=4'h5, delivered REBOTE_CICLOS+1 cycles after filas_s becomes stable.
REQ-031 Bounce filas between 0100 and 0000 every 3 cycles for 15 cycles, then hold 0100 on column 0010 -> no pulse during the bounce, then one digito_stb with digito=4'h8.
REQ-032 Press '*', release, press '#', release -> one cancelar pulse, then one aceptar pulse; digito_stb stays 0 throughout.
REQ-033 Hold '0' for 200 cycles -> a single digito_stb with digito=0; columnas stays 0010 until 8 cycles after release.
REQ-034 Drive filas=0011 in any column -> no pulse, and columnas keeps rotating with period 4*SCAN_CICLOS.
REQ-035 Pull reset low during REBOTE_PRES for '9', then release reset with the key still held -> no pulse from the aborted press; columnas=0001, and one digito_stb with digito=4'h9 follows when column 0100 is next debounced.
